// File: rtl/i2c_regfile_ctrl.sv
// i2c_regfile_ctrl: maps the I2C slave byte interface onto a bank of DEPTH
// 8-bit registers with an auto-incrementing pointer, shared with a host port.
module i2c_regfile_ctrl #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rx_active,
  input  logic          rx_valid,
  input  logic [7:0]    rx_byte,
  input  logic          tx_req,
  input  logic          tx_ready,
  output logic          tx_load,
  output logic [7:0]    tx_data,
  input  logic [AW-1:0] host_addr,
  input  logic          host_we,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  output logic          host_conflict,
  output logic          ptr_oor,
  output logic          busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_PTR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_LOAD = 3'd3,
    ST_RD_WAIT = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [7:0]    regs_q [DEPTH];
  logic [7:0]    regs_d [DEPTH];
  logic          tx_load_q, tx_load_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          conflict_q, conflict_d;
  logic          oor_q, oor_d;
  logic          busy_q, busy_d;
  logic          i2c_we_c;

  // An I2C register write happens on every received data byte
  assign i2c_we_c = (state_q == ST_WR_DATA) && rx_valid;

  // Next-state, pointer, register bank and output computation
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    regs_d     = regs_q;
    tx_load_d  = 1'b0;
    tx_data_d  = tx_data_q;
    conflict_d = 1'b0;
    oor_d      = oor_q;

    case (state_q)
      ST_IDLE: begin
        tx_data_d = regs_q[ptr_q];
        if (rx_active) begin
          state_d = ST_GET_PTR;
        end else if (tx_req) begin
          state_d = ST_RD_LOAD;
        end
      end

      ST_GET_PTR: begin
        if (rx_valid) begin
          ptr_d = rx_byte[AW-1:0];
          oor_d = (rx_byte >= 8'(DEPTH));
        end
        if (!rx_active) begin
          state_d = ST_IDLE;
        end else if (rx_valid) begin
          state_d = ST_WR_DATA;
        end
      end

      ST_WR_DATA: begin
        if (rx_valid) begin
          regs_d[ptr_q] = rx_byte;
          ptr_d         = AW'(ptr_q + AW'(1));
        end
        if (!rx_active) begin
          state_d = ST_IDLE;
        end
      end

      ST_RD_LOAD: begin
        tx_data_d = regs_q[ptr_q];
        if (!tx_req) begin
          state_d = ST_IDLE;
        end else if (tx_ready) begin
          tx_load_d = 1'b1;
          ptr_d     = AW'(ptr_q + AW'(1));
          state_d   = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        // Hold off until the slave drops ready so one byte is loaded once
        if (!tx_req) begin
          state_d = ST_IDLE;
        end else if (!tx_ready) begin
          state_d = ST_RD_LOAD;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Host write loses to an I2C write targeting the same register
    if (host_we) begin
      if (i2c_we_c && (host_addr == ptr_q)) begin
        conflict_d = 1'b1;
      end else begin
        regs_d[host_addr] = host_wdata;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      tx_load_q  <= 1'b0;
      tx_data_q  <= 8'h00;
      conflict_q <= 1'b0;
      oor_q      <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      tx_load_q  <= tx_load_d;
      tx_data_q  <= tx_data_d;
      conflict_q <= conflict_d;
      oor_q      <= oor_d;
      busy_q     <= busy_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign tx_load       = tx_load_q;
  assign tx_data       = tx_data_q;
  assign host_conflict = conflict_q;
  assign ptr_oor       = oor_q;
  assign busy          = busy_q;
  assign host_rdata    = regs_q[host_addr];

endmodule

// File: tb/tb_i2c_regfile_ctrl.sv
// Testbench for i2c_regfile_ctrl: directed scenarios plus randomized sessions
// checked against an array-based model of the register bank and pointer.
module tb_i2c_regfile_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clock = 1'b0;
  logic          reset;
  logic          rx_active, rx_valid, tx_req, tx_ready, host_we;
  logic [7:0]    rx_byte, host_wdata;
  logic [AW-1:0] host_addr;
  logic          tx_load, host_conflict, ptr_oor, busy;
  logic [7:0]    tx_data, host_rdata;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [DEPTH];
  int         mptr;
  bit         moor;

  i2c_regfile_ctrl #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .rx_active(rx_active), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_req(tx_req), .tx_ready(tx_ready), .tx_load(tx_load), .tx_data(tx_data),
    .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_conflict(host_conflict),
    .ptr_oor(ptr_oor), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 8'h00;
    mptr = 0;
    moor = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < int'(DEPTH); i++) begin
      host_addr = AW'(i);
      @(negedge clock);
      checks++;
      if (host_rdata !== mem[i]) begin
        failures++;
        $display("FAIL %s reg[%0d]: got %02h expected %02h", tag, i, host_rdata, mem[i]);
      end
    end
    step();
  endtask

  // Master-write session: pointer byte then n data bytes; optional host write
  // colliding (or not) with the first data byte.
  task automatic wr_session(input logic [7:0] pb, input logic [7:0] d [4], input int n,
                            input bit hcol);
    logic [AW-1:0] ha;
    logic [7:0]    hd;
    bit            conf;
    rx_active = 1'b1;
    step();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL wr_busy: got %0b expected 1", busy);
    end
    rx_valid = 1'b1; rx_byte = pb;
    step();
    rx_valid = 1'b0;
    mptr = int'(pb) % int'(DEPTH);
    moor = (int'(pb) >= int'(DEPTH));
    step();
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1; rx_byte = d[i];
      conf = 1'b0;
      if (hcol && i == 0) begin
        ha = ($urandom_range(0, 1) == 0) ? AW'(mptr) : AW'($urandom_range(0, DEPTH - 1));
        hd = 8'($urandom_range(0, 255));
        host_we = 1'b1; host_addr = ha; host_wdata = hd;
        conf = (int'(ha) == mptr);
      end
      step();
      rx_valid = 1'b0; host_we = 1'b0;
      mem[mptr] = d[i];
      if (hcol && i == 0) begin
        if (!conf) mem[ha] = hd;
        checks++;
        if (host_conflict !== conf) begin
          failures++;
          $display("FAIL conflict_pulse: got %0b expected %0b", host_conflict, conf);
        end
        step();
        checks++;
        if (host_conflict !== 1'b0) begin
          failures++;
          $display("FAIL conflict_width: got %0b expected 0", host_conflict);
        end
      end else if ($urandom_range(0, 1) == 1) begin
        step();
      end
      mptr = (mptr + 1) % int'(DEPTH);
    end
    rx_active = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || ptr_oor !== moor) begin
      failures++;
      $display("FAIL wr_end: busy=%0b oor=%0b expected busy=0 oor=%0b", busy, ptr_oor, moor);
    end
  endtask

  // Master-read session of n bytes; hold<0 picks a random ready-high time
  task automatic rd_session(input int n, input int hold);
    int h;
    tx_req = 1'b1;
    step();
    step();
    checks++;
    if (busy !== 1'b1 || tx_load !== 1'b0 || tx_data !== mem[mptr]) begin
      failures++;
      $display("FAIL rd_pre: busy=%0b load=%0b data=%02h expected 1 0 %02h",
               busy, tx_load, tx_data, mem[mptr]);
    end
    for (int k = 0; k < n; k++) begin
      tx_ready = 1'b1;
      step();
      checks++;
      if (tx_load !== 1'b1 || tx_data !== mem[mptr]) begin
        failures++;
        $display("FAIL rd_load%0d: load=%0b data=%02h expected 1 %02h",
                 k, tx_load, tx_data, mem[mptr]);
      end
      mptr = (mptr + 1) % int'(DEPTH);
      h = (hold < 0) ? int'($urandom_range(1, 5)) : hold;
      for (int j = 0; j < h; j++) begin
        rx_valid = (j == 0); rx_byte = 8'hC3;
        step();
        rx_valid = 1'b0;
        checks++;
        if (tx_load !== 1'b0) begin
          failures++;
          $display("FAIL rd_double_load: got %0b expected 0", tx_load);
        end
      end
      tx_ready = 1'b0;
      step();
    end
    tx_req = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || tx_load !== 1'b0) begin
      failures++;
      $display("FAIL rd_end: busy=%0b load=%0b expected 0 0", busy, tx_load);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx_active = 0; rx_valid = 0; rx_byte = 0; tx_req = 0; tx_ready = 0;
    host_we = 0; host_addr = '0; host_wdata = 0;
    model_reset();
    repeat (2) step();
    checks++;
    if (tx_load !== 0 || tx_data !== 8'h00 || host_conflict !== 0 || ptr_oor !== 0
        || busy !== 0 || host_rdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: load=%0b data=%02h conf=%0b oor=%0b busy=%0b rdata=%02h expected all 0",
               tx_load, tx_data, host_conflict, ptr_oor, busy, host_rdata);
    end
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    logic [7:0] d [4];
    d = '{8'hA5, 8'h5A, 8'h00, 8'h00};
    wr_session(8'h02, d, 2, 1'b0);
    check_regs("basic_write");
    wr_session(8'h03, d, 0, 1'b0);
    rd_session(3, 5);
    rd_session(1, 1);
  endtask

  task automatic test_wrap_oor();
    logic [7:0] d [4];
    d = '{8'h11, 8'h22, 8'h00, 8'h00};
    wr_session(8'h07, d, 2, 1'b0);
    check_regs("wrap");
    rd_session(1, 2);
    wr_session(8'h0B, d, 0, 1'b0);
    rd_session(2, 1);
    wr_session(8'h01, d, 0, 1'b0);
  endtask

  task automatic test_collision();
    for (int r = 0; r < 2; r++) begin
      rx_active = 1'b1;
      step();
      rx_valid = 1'b1; rx_byte = 8'h04;
      step();
      rx_valid = 1'b0;
      step();
      rx_valid = 1'b1; rx_byte = 8'h33;
      host_we = 1'b1; host_addr = AW'(4 + r); host_wdata = 8'h99;
      step();
      rx_valid = 1'b0; host_we = 1'b0;
      mem[4] = 8'h33;
      if (r == 1) mem[5] = 8'h99;
      mptr = 5; moor = 1'b0;
      checks++;
      if (host_conflict !== (r == 0)) begin
        failures++;
        $display("FAIL collision%0d: conflict got %0b expected %0b", r, host_conflict, r == 0);
      end
      step();
      checks++;
      if (host_conflict !== 1'b0) begin
        failures++;
        $display("FAIL collision%0d_width: got %0b expected 0", r, host_conflict);
      end
      rx_active = 1'b0;
      step();
      check_regs("collision");
    end
  endtask

  task automatic test_reset_mid_session();
    rx_active = 1'b1;
    step();
    rx_valid = 1'b1; rx_byte = 8'h02;
    step();
    rx_valid = 1'b1; rx_byte = 8'hEE;
    #2;
    reset = 1'b0;
    #1;
    rx_valid = 1'b0;
    model_reset();
    checks++;
    if (busy !== 0 || tx_load !== 0 || ptr_oor !== 0 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid: busy=%0b load=%0b oor=%0b data=%02h expected 0",
               busy, tx_load, ptr_oor, tx_data);
    end
    check_regs("reset_mid");
    @(negedge clock);
    reset = 1'b1;
    step();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_restart: busy got %0b expected 1", busy);
    end
    rx_valid = 1'b1; rx_byte = 8'h06;
    step();
    rx_valid = 1'b0;
    step();
    rx_valid = 1'b1; rx_byte = 8'h77;
    step();
    rx_valid = 1'b0; rx_active = 1'b0;
    mem[6] = 8'h77; mptr = 7;
    step();
    check_regs("reset_restart");
  endtask

  task automatic test_random();
    logic [7:0] d [4];
    logic [7:0] pb;
    int         n;
    logic [AW-1:0] ha;
    for (int it = 0; it < 25; it++) begin
      pb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      n  = int'($urandom_range(0, 4));
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom_range(0, 255));
      wr_session(pb, d, n, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) begin
        ha = AW'($urandom_range(0, DEPTH - 1));
        host_we = 1'b1; host_addr = ha; host_wdata = 8'($urandom_range(0, 255));
        mem[ha] = host_wdata;
        step();
        host_we = 1'b0;
      end
      rd_session(int'($urandom_range(1, 4)), -1);
      check_regs("random");
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap_oor();
    test_collision();
    test_reset_mid_session();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
